// File: rtl/hazard_ctrl.sv
// hazard_ctrl: ID-stage hazard controller for the 5-stage RISC-V pipeline.
// Produces operand forwarding selects, load-use bubbles, taken-redirect
// flushes and a data-memory wait freeze.
// Optional build macro: HAZARD_PERF_EN adds perf_stall_cnt / perf_flush_cnt.
module hazard_ctrl #(
    parameter int ADDR_W      = 5,
    parameter int FWD_EN      = 1,
    parameter int LU_BUBBLES  = 1,
    parameter int FLUSH_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] id_rs1_addr,
    input  logic [ADDR_W-1:0] id_rs2_addr,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [ADDR_W-1:0] ex_rd_addr,
    input  logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [ADDR_W-1:0] wb_rd_addr,
    input  logic              ex_reg_write,
    input  logic              mem_reg_write,
    input  logic              wb_reg_write,
    input  logic              ex_mem_read,
    input  logic              redirect,
    input  logic              dmem_busy,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              en_IF,
    output logic              en_IFID,
    output logic              NOP_IFID,
    output logic              NOP_IDEX
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]       perf_stall_cnt,
    output logic [31:0]       perf_flush_cnt
`endif
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        FLUSH    = 2'd2
    } state_t;

    // Counter preloads: the entry cycle itself is the first bubble/squash,
    // so the multi-cycle state only has to cover the remainder.
    localparam logic [2:0] LU_CNT_INIT = (LU_BUBBLES > 1)  ? 3'(LU_BUBBLES - 2)  : 3'd0;
    localparam logic [2:0] FL_CNT_INIT = (FLUSH_DEPTH > 2) ? 3'(FLUSH_DEPTH - 3) : 3'd0;
    localparam bit         LU_MULTI    = (FWD_EN != 0) && (LU_BUBBLES > 1);
    localparam bit         FL_MULTI    = (FLUSH_DEPTH > 2);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [2:0] r_cnt;
    logic [2:0] w_cnt_nxt;
    logic [2:0] w_hit_a;      // [0] EX, [1] MEM, [2] WB
    logic [2:0] w_hit_b;
    logic       w_raw_stall;
    logic [1:0] w_fwd_a;
    logic [1:0] w_fwd_b;
    logic       w_en_if;
    logic       w_en_ifid;
    logic       w_nop_ifid;
    logic       w_nop_idex;

    function automatic logic src_hit(input logic              used,
                                     input logic [ADDR_W-1:0] src,
                                     input logic              we,
                                     input logic [ADDR_W-1:0] dst);
        return used && (src != '0) && we && (dst == src);
    endfunction

    // A load in EX has no data yet, so its match is skipped here and
    // handled as a load-use stall instead.
    function automatic logic [1:0] fwd_sel(input logic [2:0] hit, input logic ex_load);
        if (hit[0] && !ex_load) return 2'b01;
        if (hit[1])             return 2'b10;
        if (hit[2])             return 2'b11;
        return 2'b00;
    endfunction

    // Source/destination matches per pipeline stage
    always_comb begin
        w_hit_a[0] = src_hit(id_rs1_used, id_rs1_addr, ex_reg_write,  ex_rd_addr);
        w_hit_a[1] = src_hit(id_rs1_used, id_rs1_addr, mem_reg_write, mem_rd_addr);
        w_hit_a[2] = src_hit(id_rs1_used, id_rs1_addr, wb_reg_write,  wb_rd_addr);
        w_hit_b[0] = src_hit(id_rs2_used, id_rs2_addr, ex_reg_write,  ex_rd_addr);
        w_hit_b[1] = src_hit(id_rs2_used, id_rs2_addr, mem_reg_write, mem_rd_addr);
        w_hit_b[2] = src_hit(id_rs2_used, id_rs2_addr, wb_reg_write,  wb_rd_addr);
    end

    // Forwarding selects and RAW stall request
    always_comb begin
        w_fwd_a     = 2'b00;
        w_fwd_b     = 2'b00;
        w_raw_stall = 1'b0;
        if (FWD_EN != 0) begin
            w_fwd_a     = fwd_sel(w_hit_a, ex_mem_read);
            w_fwd_b     = fwd_sel(w_hit_b, ex_mem_read);
            w_raw_stall = ex_mem_read && (w_hit_a[0] || w_hit_b[0]);
        end else begin
            w_raw_stall = (|w_hit_a) || (|w_hit_b);
        end
    end

    // Next state and pipeline controls: busy > redirect > state > raw_stall
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_en_if     = 1'b1;
        w_en_ifid   = 1'b1;
        w_nop_ifid  = 1'b0;
        w_nop_idex  = 1'b0;
        if (dmem_busy) begin
            w_en_if   = 1'b0;
            w_en_ifid = 1'b0;
        end else if (redirect) begin
            w_nop_ifid = 1'b1;
            w_nop_idex = 1'b1;
            if (FL_MULTI) begin
                w_state_nxt = FLUSH;
                w_cnt_nxt   = FL_CNT_INIT;
            end else begin
                w_state_nxt = RUN;
                w_cnt_nxt   = 3'd0;
            end
        end else begin
            unique case (r_state)
                FLUSH: begin
                    w_nop_ifid = 1'b1;
                    if (r_cnt == 3'd0) w_state_nxt = RUN;
                    else               w_cnt_nxt   = r_cnt - 3'd1;
                end
                LU_STALL: begin
                    w_en_if    = 1'b0;
                    w_en_ifid  = 1'b0;
                    w_nop_idex = 1'b1;
                    if (r_cnt == 3'd0) w_state_nxt = RUN;
                    else               w_cnt_nxt   = r_cnt - 3'd1;
                end
                default: begin
                    if (w_raw_stall) begin
                        w_en_if    = 1'b0;
                        w_en_ifid  = 1'b0;
                        w_nop_idex = 1'b1;
                        if (LU_MULTI) begin
                            w_state_nxt = LU_STALL;
                            w_cnt_nxt   = LU_CNT_INIT;
                        end
                    end
                end
            endcase
        end
    end

    // Output drive; reset forces a free-running, non-forwarding pipeline
    always_comb begin
        fwd_a    = w_fwd_a;
        fwd_b    = w_fwd_b;
        en_IF    = w_en_if;
        en_IFID  = w_en_ifid;
        NOP_IFID = w_nop_ifid;
        NOP_IDEX = w_nop_idex;
        if (!rst_n) begin
            fwd_a    = 2'b00;
            fwd_b    = 2'b00;
            en_IF    = 1'b1;
            en_IFID  = 1'b1;
            NOP_IFID = 1'b0;
            NOP_IDEX = 1'b0;
        end
    end

    // State and counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_flush;

    // Saturating counts of fetch-stalled and IF/ID-squashed cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_stall <= '0;
            r_perf_flush <= '0;
        end else begin
            if (!en_IF && (r_perf_stall != '1))   r_perf_stall <= r_perf_stall + 32'd1;
            if (NOP_IFID && (r_perf_flush != '1)) r_perf_flush <= r_perf_flush + 32'd1;
        end
    end

    assign perf_stall_cnt = r_perf_stall;
    assign perf_flush_cnt = r_perf_flush;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl. Three instances share stimulus:
//   cfg0: FWD_EN=1, LU_BUBBLES=3, FLUSH_DEPTH=4
//   cfg1: FWD_EN=0 (legacy), other parameters default
//   cfg2: all defaults
// The reference model tracks outstanding bubble/flush cycles as plain counts.
module tb_hazard_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] rs1, rs2, exrd, memrd, wbrd;
    logic       u1, u2, exw, memw, wbw, exld, redir, busy;
    logic [1:0] fa [3];
    logic [1:0] fb [3];
    logic       eif [3];
    logic       eifid [3];
    logic       nif [3];
    logic       nid [3];
`ifdef HAZARD_PERF_EN
    logic [31:0] pst, pfl;
`endif

    int     n_tests = 0;
    int     n_fail  = 0;
    int     m_fwd [3] = '{1, 0, 1};
    int     m_lu  [3] = '{3, 1, 1};
    int     m_fd  [3] = '{4, 2, 2};
    int     m_fl  [3] = '{0, 0, 0};   // flush cycles still owed after a redirect
    int     m_sl  [3] = '{0, 0, 0};   // load-use bubbles still owed
    longint m_pst = 0;
    longint m_pfl = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.ADDR_W(5), .FWD_EN(1), .LU_BUBBLES(3), .FLUSH_DEPTH(4)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .id_rs1_addr(rs1), .id_rs2_addr(rs2), .id_rs1_used(u1), .id_rs2_used(u2),
        .ex_rd_addr(exrd), .mem_rd_addr(memrd), .wb_rd_addr(wbrd),
        .ex_reg_write(exw), .mem_reg_write(memw), .wb_reg_write(wbw),
        .ex_mem_read(exld), .redirect(redir), .dmem_busy(busy),
        .fwd_a(fa[0]), .fwd_b(fb[0]), .en_IF(eif[0]), .en_IFID(eifid[0]),
        .NOP_IFID(nif[0]), .NOP_IDEX(nid[0])
`ifdef HAZARD_PERF_EN
        , .perf_stall_cnt(pst), .perf_flush_cnt(pfl)
`endif
    );

    hazard_ctrl #(.FWD_EN(0)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .id_rs1_addr(rs1), .id_rs2_addr(rs2), .id_rs1_used(u1), .id_rs2_used(u2),
        .ex_rd_addr(exrd), .mem_rd_addr(memrd), .wb_rd_addr(wbrd),
        .ex_reg_write(exw), .mem_reg_write(memw), .wb_reg_write(wbw),
        .ex_mem_read(exld), .redirect(redir), .dmem_busy(busy),
        .fwd_a(fa[1]), .fwd_b(fb[1]), .en_IF(eif[1]), .en_IFID(eifid[1]),
        .NOP_IFID(nif[1]), .NOP_IDEX(nid[1])
`ifdef HAZARD_PERF_EN
        , .perf_stall_cnt(), .perf_flush_cnt()
`endif
    );

    hazard_ctrl dut2 (
        .clk(clk), .rst_n(rst_n),
        .id_rs1_addr(rs1), .id_rs2_addr(rs2), .id_rs1_used(u1), .id_rs2_used(u2),
        .ex_rd_addr(exrd), .mem_rd_addr(memrd), .wb_rd_addr(wbrd),
        .ex_reg_write(exw), .mem_reg_write(memw), .wb_reg_write(wbw),
        .ex_mem_read(exld), .redirect(redir), .dmem_busy(busy),
        .fwd_a(fa[2]), .fwd_b(fb[2]), .en_IF(eif[2]), .en_IFID(eifid[2]),
        .NOP_IFID(nif[2]), .NOP_IDEX(nid[2])
`ifdef HAZARD_PERF_EN
        , .perf_stall_cnt(), .perf_flush_cnt()
`endif
    );

    // ---------------- reference model ----------------
    function automatic logic hit(input logic u, input logic [4:0] s, input logic w, input logic [4:0] d);
        return u && (s != 5'd0) && w && (d == s);
    endfunction

    function automatic logic [1:0] pick(input logic he, input logic hm, input logic hw);
        if (he && !exld) return 2'b01;
        if (hm) return 2'b10;
        if (hw) return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic m_raw(input int c);
        logic ea, eb, any;
        ea  = hit(u1, rs1, exw, exrd);
        eb  = hit(u2, rs2, exw, exrd);
        any = ea || eb || hit(u1, rs1, memw, memrd) || hit(u1, rs1, wbw, wbrd)
              || hit(u2, rs2, memw, memrd) || hit(u2, rs2, wbw, wbrd);
        return (m_fwd[c] != 0) ? (exld && (ea || eb)) : any;
    endfunction

    // Expected {fwd_a, fwd_b, en_IF, en_IFID, NOP_IFID, NOP_IDEX}
    function automatic logic [7:0] m_out(input int c);
        logic [1:0] a, b;
        logic [3:0] ctl;
        if (!rst_n) return 8'b0000_1100;
        a = 2'b00;
        b = 2'b00;
        if (m_fwd[c] != 0) begin
            a = pick(hit(u1, rs1, exw, exrd), hit(u1, rs1, memw, memrd), hit(u1, rs1, wbw, wbrd));
            b = pick(hit(u2, rs2, exw, exrd), hit(u2, rs2, memw, memrd), hit(u2, rs2, wbw, wbrd));
        end
        if (busy)                             ctl = 4'b0000;
        else if (redir)                       ctl = 4'b1111;
        else if (m_fl[c] > 0)                 ctl = 4'b1110;
        else if (m_sl[c] > 0 || m_raw(c))     ctl = 4'b0001;
        else                                  ctl = 4'b1100;
        return {a, b, ctl};
    endfunction

    function automatic logic [7:0] act(input int c);
        return {fa[c], fb[c], eif[c], eifid[c], nif[c], nid[c]};
    endfunction

    // Advance the model across one rising edge using the current inputs
    task automatic m_step();
        for (int c = 0; c < 3; c++) begin
            logic [7:0] o;
            o = m_out(c);
            if (c == 0) begin
                if (!rst_n) begin
                    m_pst = 0;
                    m_pfl = 0;
                end else begin
                    if (!o[3]) m_pst++;
                    if (o[1])  m_pfl++;
                end
            end
            if (!rst_n) begin
                m_fl[c] = 0;
                m_sl[c] = 0;
            end else if (busy) begin
                m_fl[c] = m_fl[c];
            end else if (redir) begin
                m_fl[c] = m_fd[c] - 2;
                m_sl[c] = 0;
            end else if (m_fl[c] > 0) begin
                m_fl[c]--;
            end else if (m_sl[c] > 0) begin
                m_sl[c]--;
            end else if (m_raw(c) && m_fwd[c] != 0) begin
                m_sl[c] = m_lu[c] - 1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        m_step();
        @(negedge clk);
    endtask

    task automatic idle();
        rs1 = '0; rs2 = '0; exrd = '0; memrd = '0; wbrd = '0;
        u1 = 0; u2 = 0; exw = 0; memw = 0; wbw = 0; exld = 0; redir = 0; busy = 0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle();
        u1 = 1; rs1 = 5; exw = 1; exrd = 5; redir = 1;
        tick();
        #1;
        for (int c = 0; c < 3; c++) begin
            n_tests++;
            if (act(c) !== m_out(c)) begin
                n_fail++;
                $display("FAIL reset_out cfg%0d: got %b want %b", c, act(c), m_out(c));
            end
        end
        n_tests++;
        if ({fa[0], eif[0], nif[0]} !== 4'b0010) begin
            n_fail++;
            $display("FAIL reset_forced: got %b want 0010", {fa[0], eif[0], nif[0]});
        end
`ifdef HAZARD_PERF_EN
        n_tests++;
        if (pst !== 32'd0 || pfl !== 32'd0) begin
            n_fail++;
            $display("FAIL perf_reset: got %0d/%0d want 0/0", pst, pfl);
        end
`endif
        tick();
        rst_n = 1;
        idle();
        tick();
    endtask

    task automatic test_forward();
        idle(); u1 = 1; rs1 = 5; exw = 1; exrd = 5;
        #1;
        for (int c = 0; c < 3; c++) begin
            n_tests++;
            if (act(c) !== m_out(c)) begin
                n_fail++;
                $display("FAIL fwd_ex cfg%0d: got %b want %b", c, act(c), m_out(c));
            end
        end
        n_tests++;
        if ({fa[0], eif[0], eif[1]} !== 4'b0110) begin
            n_fail++;
            $display("FAIL fwd_ex_sel: got %b want 0110", {fa[0], eif[0], eif[1]});
        end
        tick();
        idle(); u1 = 1; rs1 = 5; wbw = 1; wbrd = 5;
        #1;
        for (int c = 0; c < 3; c++) begin
            n_tests++;
            if (act(c) !== m_out(c)) begin
                n_fail++;
                $display("FAIL fwd_wb cfg%0d: got %b want %b", c, act(c), m_out(c));
            end
        end
        n_tests++;
        if ({fa[0], fa[1]} !== 4'b1100) begin
            n_fail++;
            $display("FAIL fwd_wb_sel: got %b want 1100", {fa[0], fa[1]});
        end
        tick();
    endtask

    task automatic test_x0();
        idle(); u1 = 1; rs1 = 0; u2 = 1; rs2 = 0; exw = 1; exrd = 0;
        #1;
        for (int c = 0; c < 3; c++) begin
            n_tests++;
            if (act(c) !== m_out(c)) begin
                n_fail++;
                $display("FAIL x0 cfg%0d: got %b want %b", c, act(c), m_out(c));
            end
        end
        n_tests++;
        if ({fa[0], fb[0], eif[0], eif[1]} !== 6'b000011) begin
            n_fail++;
            $display("FAIL x0_nohit: got %b want 000011", {fa[0], fb[0], eif[0], eif[1]});
        end
        tick();
    endtask

    task automatic test_load_use();
        int stalls = 0;
        for (int k = 0; k < 5; k++) begin
            idle(); u1 = 1; rs1 = 7;
            if (k == 0) begin exw = 1; exld = 1; exrd = 7; end
            else        begin memw = 1; memrd = 7; end
            #1;
            for (int c = 0; c < 3; c++) begin
                n_tests++;
                if (act(c) !== m_out(c)) begin
                    n_fail++;
                    $display("FAIL load_use cfg%0d k%0d: got %b want %b", c, k, act(c), m_out(c));
                end
            end
            if (!eif[0] && nid[0]) stalls++;
            if (k == 3) begin
                n_tests++;
                if ({fa[0], eif[0]} !== 3'b101) begin
                    n_fail++;
                    $display("FAIL lu_resume: got %b want 101", {fa[0], eif[0]});
                end
            end
            tick();
        end
        n_tests++;
        if (stalls != 3) begin
            n_fail++;
            $display("FAIL lu_bubbles: got %0d want 3", stalls);
        end
    endtask

    task automatic test_redirect();
        for (int k = 0; k < 5; k++) begin
            idle(); redir = (k == 0);
            #1;
            for (int c = 0; c < 3; c++) begin
                n_tests++;
                if (act(c) !== m_out(c)) begin
                    n_fail++;
                    $display("FAIL redirect cfg%0d k%0d: got %b want %b", c, k, act(c), m_out(c));
                end
            end
            n_tests++;
            if ({nif[0], nid[0], nif[2]} !== {k < 3, k == 0, k == 0}) begin
                n_fail++;
                $display("FAIL flush_pattern k%0d: got %b want %b", k,
                         {nif[0], nid[0], nif[2]}, {k < 3, k == 0, k == 0});
            end
            tick();
        end
    endtask

    task automatic test_freeze();
        idle(); redir = 1;
        #1;
        tick();
        idle(); busy = 1;
        for (int k = 0; k < 4; k++) begin
            #1;
            for (int c = 0; c < 3; c++) begin
                n_tests++;
                if (act(c) !== m_out(c)) begin
                    n_fail++;
                    $display("FAIL freeze cfg%0d k%0d: got %b want %b", c, k, act(c), m_out(c));
                end
            end
            n_tests++;
            if ({eif[0], eifid[0], nif[0], nid[0]} !== 4'b0000) begin
                n_fail++;
                $display("FAIL freeze_ctl k%0d: got %b want 0000", k, {eif[0], eifid[0], nif[0], nid[0]});
            end
            tick();
        end
        busy = 0;
        for (int k = 0; k < 3; k++) begin
            #1;
            for (int c = 0; c < 3; c++) begin
                n_tests++;
                if (act(c) !== m_out(c)) begin
                    n_fail++;
                    $display("FAIL unfreeze cfg%0d k%0d: got %b want %b", c, k, act(c), m_out(c));
                end
            end
            n_tests++;
            if ({eif[0], nif[0]} !== {1'b1, k < 2}) begin
                n_fail++;
                $display("FAIL flush_resume k%0d: got %b want %b", k, {eif[0], nif[0]}, {1'b1, k < 2});
            end
            tick();
        end
        idle(); redir = 1; exw = 1; exld = 1; exrd = 7; u1 = 1; rs1 = 7;
        #1;
        n_tests++;
        if ({eif[0], nif[0], nid[0]} !== 3'b111) begin
            n_fail++;
            $display("FAIL redirect_wins: got %b want 111", {eif[0], nif[0], nid[0]});
        end
        tick();
        for (int k = 0; k < 3; k++) begin
            idle();
            #1;
            n_tests++;
            if ({eif[0], eif[2]} !== 2'b11) begin
                n_fail++;
                $display("FAIL no_lu_after_redirect k%0d: got %b want 11", k, {eif[0], eif[2]});
            end
            tick();
        end
    endtask

    task automatic test_legacy();
        for (int k = 0; k < 3; k++) begin
            idle(); u2 = 1; rs2 = 9;
            if (k == 0) begin memw = 1; memrd = 9; end
            if (k == 1) begin wbw = 1; wbrd = 9; end
            #1;
            for (int c = 0; c < 3; c++) begin
                n_tests++;
                if (act(c) !== m_out(c)) begin
                    n_fail++;
                    $display("FAIL legacy cfg%0d k%0d: got %b want %b", c, k, act(c), m_out(c));
                end
            end
            n_tests++;
            if ({eif[1], fb[1], eif[0]} !== {k == 2, 2'b00, 1'b1}) begin
                n_fail++;
                $display("FAIL legacy_stall k%0d: got %b want %b", k, {eif[1], fb[1], eif[0]},
                         {k == 2, 2'b00, 1'b1});
            end
            tick();
        end
    endtask

    task automatic test_async_reset();
        idle(); u1 = 1; rs1 = 7; exw = 1; exld = 1; exrd = 7;
        #1;
        tick();
        idle(); u1 = 1; rs1 = 7; memw = 1; memrd = 7;
        #1;
        n_tests++;
        if (eif[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL in_lu_stall: got %b want 0", eif[0]);
        end
        #2;
        rst_n = 0;
        for (int c = 0; c < 3; c++) begin
            m_fl[c] = 0;
            m_sl[c] = 0;
        end
        m_pst = 0;
        m_pfl = 0;
        #1;
        for (int c = 0; c < 3; c++) begin
            n_tests++;
            if (act(c) !== m_out(c)) begin
                n_fail++;
                $display("FAIL async_reset cfg%0d: got %b want %b", c, act(c), m_out(c));
            end
        end
        n_tests++;
        if ({eif[0], nid[0], fa[0]} !== 4'b1000) begin
            n_fail++;
            $display("FAIL async_reset_ctl: got %b want 1000", {eif[0], nid[0], fa[0]});
        end
`ifdef HAZARD_PERF_EN
        n_tests++;
        if (pst !== 32'd0 || pfl !== 32'd0) begin
            n_fail++;
            $display("FAIL perf_async_reset: got %0d/%0d want 0/0", pst, pfl);
        end
`endif
        tick();
        rst_n = 1;
        #1;
        n_tests++;
        if ({eif[0], act(0)} !== {1'b1, m_out(0)}) begin
            n_fail++;
            $display("FAIL post_reset: got %b want %b", act(0), m_out(0));
        end
        idle();
        tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            rs1   = 5'($urandom_range(0, 3));
            rs2   = 5'($urandom_range(0, 3));
            exrd  = 5'($urandom_range(0, 3));
            memrd = 5'($urandom_range(0, 3));
            wbrd  = 5'($urandom_range(0, 3));
            u1    = ($urandom_range(0, 3) != 0);
            u2    = ($urandom_range(0, 3) != 0);
            exw   = ($urandom_range(0, 9) < 6);
            memw  = ($urandom_range(0, 9) < 6);
            wbw   = ($urandom_range(0, 9) < 6);
            exld  = exw && ($urandom_range(0, 2) == 0);
            redir = ($urandom_range(0, 11) == 0);
            busy  = ($urandom_range(0, 9) == 0);
            #1;
            for (int c = 0; c < 3; c++) begin
                n_tests++;
                if (act(c) !== m_out(c)) begin
                    n_fail++;
                    $display("FAIL random cfg%0d n%0d: got %b want %b", c, n, act(c), m_out(c));
                end
            end
`ifdef HAZARD_PERF_EN
            n_tests++;
            if (pst !== 32'(m_pst) || pfl !== 32'(m_pfl)) begin
                n_fail++;
                $display("FAIL perf_counts n%0d: got %0d/%0d want %0d/%0d", n, pst, pfl, m_pst, m_pfl);
            end
`endif
            tick();
        end
    endtask

    initial begin
        rst_n = 0;
        idle();
        @(negedge clk);
        test_reset();
        test_forward();
        test_x0();
        test_load_use();
        test_redirect();
        test_freeze();
        test_legacy();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Parametrised pipeline hazard controller for the 5-stage RISC-V core. Replaces blanket stalling with decode-stage forwarding selects, load-use bubbles and taken-redirect flushes.
- Adds a data-memory wait freeze.
- Sits beside the ID stage. Drives the IF/PC enable, the IF/ID enable and the IF/ID and ID/EX NOP inputs, plus the ID operand mux selects.

Parameters:
- ADDR_W, 5, register address width.
- FWD_EN, 1, 1 = forward from EX/MEM/WB; 0 = stall on any RAW match (legacy mode).
- LU_BUBBLES, 1, bubbles inserted per load-use hazard (1..7).
- FLUSH_DEPTH, 2, younger instructions squashed on a redirect (2..7).

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- id_rs1_addr, id_rs2_addr  in  ADDR_W each  ID source addresses.
- id_rs1_used, id_rs2_used  in  1 each  source actually read.
- ex_rd_addr, mem_rd_addr, wb_rd_addr  in  ADDR_W each  destination addresses in EX, MEM, WB.
- ex_reg_write, mem_reg_write, wb_reg_write  in  1 each  destination write enables.
- ex_mem_read  in  1  instruction in EX is a load.
- redirect  in  1  branch taken or jump resolved in EX this cycle.
- dmem_busy  in  1  data memory not ready; pipeline must freeze.
- fwd_a, fwd_b  out  2 each  operand select: 00 RF, 01 EX, 10 MEM, 11 WB.
- en_IF, en_IFID  out  1 each  PC and IF/ID register enables.
- NOP_IFID, NOP_IDEX  out  1 each  bubble insert.

Behaviour:
- Match definition:
  - rsX_hit(S) = id_rsX_used && id_rsX_addr!=0 && S_reg_write && S_rd_addr==id_rsX_addr.
  - x0 never matches.
- Forwarding (combinational, FWD_EN=1):
  - Priority EX > MEM > WB; no hit gives 00.
  - An EX hit by a load is not forwarded; it yields load-use.
  - FWD_EN=0: fwd_a and fwd_b tie to 00.
- raw_stall:
  - FWD_EN=1: EX hit with ex_mem_read.
  - FWD_EN=0: any hit in EX, MEM or WB.
- FSM states: RUN, LU_STALL, FLUSH. A 3-bit counter cnt supports the multi-cycle states.
- Priority each cycle: dmem_busy > redirect > state action > raw_stall.
- dmem_busy=1:
  - en_IF=0, en_IFID=0, NOP_IFID=0, NOP_IDEX=0.
  - State and cnt hold; redirect is ignored that cycle and stays asserted by the frozen EX stage.
- redirect (not busy), any state:
  - en_IF=1, en_IFID=1, NOP_IFID=1, NOP_IDEX=1.
  - If FLUSH_DEPTH>2: next state FLUSH, cnt<=FLUSH_DEPTH-3. Otherwise RUN.
  - Any pending LU_STALL is abandoned.
- FLUSH:
  - NOP_IFID=1, enables 1, NOP_IDEX=0.
  - cnt==0 returns to RUN; otherwise cnt decrements.
- raw_stall in RUN:
  - en_IF=0, en_IFID=0, NOP_IDEX=1, NOP_IFID=0.
  - FWD_EN=1 and LU_BUBBLES>1: go LU_STALL, cnt<=LU_BUBBLES-2.
  - FWD_EN=0: stay RUN; re-evaluate every cycle until no hit.
- LU_STALL:
  - Same outputs as raw_stall.
  - cnt==0 returns to RUN; otherwise cnt decrements.
- RUN with no event: en=1, NOP=0.
- Reset (rst_n low, asynchronous): state RUN, cnt 0. Outputs forced to en_IF=1, en_IFID=1, NOP_IFID=0, NOP_IDEX=0, fwd=00 while asserted. Normal evaluation resumes on the first clk edge after release.

Optional Feature:
- HAZARD_PERF_EN defined:
  - Adds output ports perf_stall_cnt [31:0] and perf_flush_cnt [31:0].
  - Counters are reset to 0 by rst_n and saturate at 2^32-1.
  - perf_stall_cnt increments on every cycle with en_IF=0.
  - perf_flush_cnt increments on every cycle with NOP_IFID=1.
- Undefined: ports and counters are absent; functional behaviour is identical.

Test Plan:
- Defaults. ADD x5 in EX, ID reads x5 as rs1 -> fwd_a=01, no stall. Then only WB writes x5 -> fwd_a=11.
- x0 hazard. EX writes x0, ID rs1=x0 -> fwd_a=00, no stall.
- Load-use, LU_BUBBLES=3. Load x7 in EX, ID uses x7 -> en_IF=0 and NOP_IDEX=1 for exactly 3 cycles, then RUN with fwd from MEM/WB.
- Redirect, FLUSH_DEPTH=4. One-cycle redirect pulse -> NOP_IFID=1 for 3 consecutive cycles; NOP_IDEX=1 only in the first.
- Priority/freeze. dmem_busy held 4 cycles during FLUSH with cnt=1 -> all enables 0 and cnt unchanged. After release, 2 more flush cycles then RUN. Redirect plus load-use in the same cycle -> redirect wins, no LU_STALL.
- FWD_EN=0 and reset. ID rs2 matches MEM dest -> stall until the write leaves WB. rst_n low mid-LU_STALL -> state RUN, en_IF=1 immediately (asynchronous). With HAZARD_PERF_EN, both perf counters read 0.
